flash_op_sched: RTL and testbench
=================================

# flash_op_sched

Scheduler that shares the single SPI command engine among three flash requesters: sector erase, page program and read. It arbitrates round-robin, inserts WREN (write-enable) before erase and program operations, and polls the status register until the flash is no longer busy. This replaces fixed multi-second waits after each erase with measured completion. It sits between the multiboot erase/program/read sequencers and the SPI command engine.

## Interface
Parameters:
- POLL_GAP, 4999 — idle cycles between consecutive RDSR polls (100 µs at 50 MHz).
- POLL_MAX, 40000 — maximum RDSR polls per operation before timeout.

Ports:
- sclk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  level requests: bit0 erase, bit1 program, bit2 read; each held until its done pulse
- req_addr  in  72  packed 24-bit flash addresses, requester i at [24i+23:24i]
- req_len  in  48  packed 16-bit byte counts, requester i at [16i+15:16i]; ignored for erase
- grant  out  3  one-hot, one-cycle pulse when a requester is accepted
- done  out  3  one-hot, one-cycle pulse when the granted operation completes
- err  out  1  one-cycle pulse coincident with done on poll timeout
- busy  out  1  high from grant until done, inclusive
- cmd_start  out  1  one-cycle pulse to the engine
- cmd_code  out  8  opcode, stable from cmd_start until cmd_done
- cmd_addr  out  24  address, stable alongside cmd_code
- cmd_len  out  16  data byte count, stable alongside cmd_code
- cmd_done  in  1  engine completion pulse
- rx_data  in  8  last received byte, valid in the cmd_done cycle

## Operation
- Opcodes: WREN 0x06, SE 0xD8, PP 0x02, READ 0x03, RDSR 0x05.
- States: IDLE, ARB, WREN, WREN_W, OP, OP_W, GAP, POLL, POLL_W, FIN.
- IDLE: when any req bit is high, go to ARB.
- ARB: round-robin grant, starting from the requester after the last one granted (pointer resets to erase). Latch the granted index, address and length. Pulse grant. Read goes to OP; erase and program go to WREN.
- WREN: drive cmd_start with code 0x06, addr 0, len 0. WREN_W: wait for cmd_done, then go to OP.
- OP: drive cmd_start with the opcode, latched address and latched length (len 0 for SE). OP_W: on cmd_done, read goes to FIN; erase and program go to GAP.
- GAP: count POLL_GAP+1 cycles, then go to POLL.
- POLL: drive cmd_start with code 0x05, len 1, and increment the poll counter.
- POLL_W: on cmd_done, check rx_data[0] (WIP).
  - WIP=0: go to FIN.
  - WIP=1 and poll count == POLL_MAX: go to FIN and flag a timeout.
  - WIP=1 otherwise: go to GAP.
- FIN: pulse done[idx] (and err if timed out), clear busy, advance the RR pointer, return to IDLE.
- A req drop after grant does not abort the operation. A req drop before grant is simply not served.
- cmd_done outside a *_W state is ignored.
- Counter widths: gap counter $clog2(POLL_GAP+1); poll counter $clog2(POLL_MAX+1).

## Timing
- Reset values: all outputs 0, state IDLE, RR pointer 0, counters 0. An asynchronous reset mid-operation abandons the operation immediately with no done pulse; requesters must re-request.
- req high in IDLE at edge t: ARB at t+1 (grant pulse), cmd_start at t+2.
- cmd_done at edge u: the next cmd_start is at u+1 (WREN→OP), or GAP begins at u+1.
- First RDSR cmd_start comes POLL_GAP+1 cycles after GAP entry.
- Clearing RDSR cmd_done at v: done pulses at v+1 (FIN); IDLE at v+2; the earliest next grant is at v+3.
- Read: done pulses one cycle after the READ cmd_done.
- cmd_start never coincides with an expected cmd_done.

## Structure
- Shared package flash_pkg holds:
  - opcode constants
  - state enum
  - requester indices (REQ_SE=0, REQ_PP=1, REQ_RD=2)
- One sub-module: rr_arb3, a combinational 3-way round-robin picker with a registered pointer update on an advance strobe.

## Test plan
- Erase alone (addr 0x010000), stub WIP=1 for 3 polls then 0, POLL_GAP=9 → sequence WREN, D8@0x010000, RDSR×4 with starts 10 cycles after each GAP entry; done[0] once, err 0.
- Read alone (addr 0x000100, len 256) → grant[2] then cmd_start 0x03/0x000100/256 with no WREN or RDSR; done[2] one cycle after cmd_done.
- All three req high simultaneously from reset → grant order erase, program, read. A second erase request raised during the read is granted after it.
- POLL_MAX=5 with WIP stuck at 1 → exactly 5 RDSR commands, then done[0] together with err.
- Reset asserted during the GAP of a program → all outputs 0 immediately, no done pulse. After release with req[1] still high, program restarts with WREN.
- Spurious cmd_done in IDLE → no state change and no output pulses.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the flash operation scheduler: SPI opcodes,
// requester indices and the scheduler state encoding.
package flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam logic [1:0] REQ_SE = 2'd0;
  localparam logic [1:0] REQ_PP = 2'd1;
  localparam logic [1:0] REQ_RD = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_WREN,
    S_WREN_W,
    S_OP,
    S_OP_W,
    S_GAP,
    S_POLL,
    S_POLL_W,
    S_FIN
  } state_e;

  function automatic logic [7:0] op_code(input logic [1:0] idx);
    case (idx)
      REQ_SE:  return OP_SE;
      REQ_PP:  return OP_PP;
      default: return OP_READ;
    endcase
  endfunction

  // Modulo-3 add used to walk the requester ring.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/flash_op_sched_rr_arb3.sv
// Three-way round-robin picker: combinational choice starting at the
// pointer, pointer moves past the last served requester on advance.
module rr_arb3
  import flash_pkg::*;
(
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       advance,
  input  logic [1:0] last_idx,
  output logic       valid,
  output logic [1:0] pick_idx,
  output logic [2:0] pick_onehot
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  always_comb begin
    valid    = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = 0; k < 3; k++) begin
      cand = rr_add(ptr_q, 2'(k));
      if (!valid && req[cand]) begin
        valid    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_onehot = valid ? (3'b001 << pick_idx) : 3'b000;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = rr_add(last_idx, 2'd1);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/flash_op_sched.sv
// Shares one SPI command engine between erase, program and read requesters,
// adding WREN before writes and polling RDSR until the flash is idle.
module flash_op_sched
  import flash_pkg::*;
#(
  parameter int POLL_GAP = 4999,
  parameter int POLL_MAX = 40000
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [71:0] req_addr,
  input  logic [47:0] req_len,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        err,
  output logic        busy,
  output logic        cmd_start,
  output logic [7:0]  cmd_code,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_len,
  input  logic        cmd_done,
  input  logic [7:0]  rx_data
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          tout_q, tout_d;

  logic          arb_valid;
  logic [1:0]    arb_idx;
  logic [2:0]    arb_onehot;
  logic          rr_adv;

  // Only the WIP bit of the status byte matters here.
  logic unused_rx;
  assign unused_rx = ^rx_data[7:1];

  assign rr_adv = (state_q == S_FIN);

  rr_arb3 u_arb (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .req        (req),
    .advance    (rr_adv),
    .last_idx   (idx_q),
    .valid      (arb_valid),
    .pick_idx   (arb_idx),
    .pick_onehot(arb_onehot)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      addr_q  <= 24'd0;
      len_q   <= 16'd0;
      gap_q   <= '0;
      poll_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      tout_q  <= tout_d;
    end
  end

  // The gap counter idles at zero so every GAP visit starts a fresh count.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    gap_d   = '0;
    poll_d  = poll_q;
    tout_d  = tout_q;
    unique case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB: begin
        if (arb_valid) begin
          idx_d  = arb_idx;
          poll_d = '0;
          tout_d = 1'b0;
          case (arb_idx)
            REQ_PP: begin
              addr_d = req_addr[47:24];
              len_d  = req_len[31:16];
            end
            REQ_RD: begin
              addr_d = req_addr[71:48];
              len_d  = req_len[47:32];
            end
            default: begin
              addr_d = req_addr[23:0];
              len_d  = req_len[15:0];
            end
          endcase
          state_d = (arb_idx == REQ_RD) ? S_OP : S_WREN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WREN:   state_d = S_WREN_W;
      S_WREN_W: if (cmd_done) state_d = S_OP;
      S_OP:     state_d = S_OP_W;
      S_OP_W:   if (cmd_done) state_d = (idx_q == REQ_RD) ? S_FIN : S_GAP;
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_POLL;
        else                   gap_d   = gap_q + GW'(1);
      end
      S_POLL: begin
        poll_d  = poll_q + PW'(1);
        state_d = S_POLL_W;
      end
      S_POLL_W: begin
        if (cmd_done) begin
          if (!rx_data[0]) begin
            state_d = S_FIN;
          end else if (poll_q == POLL_LAST) begin
            state_d = S_FIN;
            tout_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command fields are decoded from state so they hold through each *_W wait.
  always_comb begin
    grant     = 3'b000;
    done      = 3'b000;
    err       = 1'b0;
    busy      = 1'b0;
    cmd_start = 1'b0;
    cmd_code  = 8'h00;
    cmd_addr  = 24'd0;
    cmd_len   = 16'd0;
    unique case (state_q)
      S_ARB: begin
        grant = arb_onehot;
        busy  = arb_valid;
      end
      S_WREN, S_WREN_W: begin
        busy      = 1'b1;
        cmd_start = (state_q == S_WREN);
        cmd_code  = OP_WREN;
      end
      S_OP, S_OP_W: begin
        busy      = 1'b1;
        cmd_start = (state_q == S_OP);
        cmd_code  = op_code(idx_q);
        cmd_addr  = addr_q;
        cmd_len   = (idx_q == REQ_SE) ? 16'd0 : len_q;
      end
      S_GAP: busy = 1'b1;
      S_POLL, S_POLL_W: begin
        busy      = 1'b1;
        cmd_start = (state_q == S_POLL);
        cmd_code  = OP_RDSR;
        cmd_len   = 16'd1;
      end
      S_FIN: begin
        busy = 1'b1;
        done = 3'b001 << idx_q;
        err  = tout_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_op_sched.sv
// Directed bench for flash_op_sched: a stub SPI engine answers commands,
// a monitor logs events, and the main sequence checks them.
module tb_flash_op_sched;
  import flash_pkg::*;

  localparam int GAP  = 9;
  localparam int PMAX = 5;
  localparam int LAT  = 2;

  logic        sclk;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [71:0] req_addr = '0;
  logic [47:0] req_len = '0;
  logic [2:0]  grant, done;
  logic        err, busy, cmd_start;
  logic [7:0]  cmd_code;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int wipPolls = 0;
  int injectCnt = 0;
  int overlapCnt = 0;
  int unstableCnt = 0;
  int errPulses = 0;

  int          sCyc[$];
  logic [7:0]  sCode[$];
  logic [23:0] sAddr[$];
  logic [15:0] sLen[$];
  int          cdCyc[$];
  int          gCyc[$];
  logic [2:0]  gVec[$];
  logic        gBusy[$];
  int          dCyc[$];
  logic [2:0]  dVec[$];
  logic        dErr[$];
  logic        dBusy[$];

  flash_op_sched #(.POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .cmd_start(cmd_start),
    .cmd_code (cmd_code),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_done (cmd_done),
    .rx_data  (rx_data)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stub engine: answers each command LAT cycles later; RDSR reports WIP=1
  // for the first wipPolls polls of an operation.
  initial begin : engineStub
    int seenInject;
    int rdsrSeen;
    seenInject = 0;
    rdsrSeen   = 0;
    forever begin
      if (injectCnt != seenInject) begin
        seenInject = injectCnt;
        cmd_done = 1'b1;
        rx_data  = 8'h01;
        @(posedge sclk); #1;
        cmd_done = 1'b0;
        rx_data  = 8'h00;
      end else if (rst_n && cmd_start) begin
        if (cmd_code == OP_RDSR) rdsrSeen++;
        else                     rdsrSeen = 0;
        repeat (LAT) @(posedge sclk);
        #1;
        cmd_done = 1'b1;
        if (cmd_code == OP_RDSR) rx_data = (rdsrSeen <= wipPolls) ? 8'h01 : 8'hFE;
        else                     rx_data = 8'h01;
        @(posedge sclk); #1;
        cmd_done = 1'b0;
        rx_data  = 8'h00;
      end else begin
        @(posedge sclk); #1;
      end
    end
  end

  initial begin : monitor
    logic [7:0]  curCode;
    logic [23:0] curAddr;
    logic [15:0] curLen;
    logic        outstanding;
    outstanding = 1'b0;
    curCode = '0;
    curAddr = '0;
    curLen  = '0;
    forever begin
      @(negedge sclk);
      cycle++;
      if (!rst_n) outstanding = 1'b0;
      if (cmd_start && cmd_done) overlapCnt++;
      if (cmd_start) begin
        sCyc.push_back(cycle);
        sCode.push_back(cmd_code);
        sAddr.push_back(cmd_addr);
        sLen.push_back(cmd_len);
        curCode = cmd_code;
        curAddr = cmd_addr;
        curLen  = cmd_len;
        outstanding = 1'b1;
      end else if (outstanding && ({cmd_code, cmd_addr, cmd_len} !== {curCode, curAddr, curLen})) begin
        unstableCnt++;
      end
      if (cmd_done) begin
        cdCyc.push_back(cycle);
        outstanding = 1'b0;
      end
      if (|grant) begin
        gCyc.push_back(cycle);
        gVec.push_back(grant);
        gBusy.push_back(busy);
      end
      if (|done) begin
        dCyc.push_back(cycle);
        dVec.push_back(done);
        dErr.push_back(err);
        dBusy.push_back(busy);
      end
      if (err) errPulses++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [23:0] addr, input logic [15:0] len);
    req_addr[24*idx +: 24] = addr;
    req_len[16*idx +: 16]  = len;
    req[idx] = 1'b1;
  endtask

  // Requesters drop their line on their own done pulse.
  task automatic stepCycle();
    @(negedge sclk); #1;
    req = req & ~done;
  endtask

  function automatic int logSize(input int which);
    case (which)
      0:       return sCyc.size();
      1:       return cdCyc.size();
      2:       return gCyc.size();
      default: return dCyc.size();
    endcase
  endfunction

  task automatic waitFor(input string tag, input int which, input int target, input int limit);
    int n;
    n = 0;
    while (logSize(which) < target && n < limit) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(logSize(which)), 32'(target));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_start"}, 32'(cmd_start), 32'd0);
    checkOutput({tag, "_code"}, 32'(cmd_code), 32'd0);
    checkOutput({tag, "_addr"}, 32'(cmd_addr), 32'd0);
    checkOutput({tag, "_len"}, 32'(cmd_len), 32'd0);
  endtask

  initial begin : mainSeq
    int sb, cb, gb, db, ep, n;
    logic [7:0] eraseCodes [6];
    logic [7:0] mixCodes [10];
    eraseCodes = '{8'h06, 8'hD8, 8'h05, 8'h05, 8'h05, 8'h05};
    mixCodes   = '{8'h06, 8'hD8, 8'h05, 8'h06, 8'h02, 8'h05, 8'h03, 8'h06, 8'hD8, 8'h05};

    rst_n = 1'b0;
    repeat (3) stepCycle();
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] spurious cmd_done in IDLE");
    sb = sCyc.size(); gb = gCyc.size(); db = dCyc.size();
    injectCnt++;
    repeat (6) stepCycle();
    checkOutput("spur_starts", 32'(sCyc.size() - sb), 32'd0);
    checkOutput("spur_grants", 32'(gCyc.size() - gb), 32'd0);
    checkOutput("spur_dones", 32'(dCyc.size() - db), 32'd0);
    checkOutput("spur_busy", 32'(busy), 32'd0);

    $display("[TB] erase alone, WIP for 3 polls");
    sb = sCyc.size(); cb = cdCyc.size(); gb = gCyc.size(); db = dCyc.size(); ep = errPulses;
    wipPolls = 3;
    applyStimulus(0, 24'h010000, 16'h0000);
    waitFor("erase_done_seen", 3, db + 1, 400);
    repeat (4) stepCycle();
    checkOutput("erase_grant", 32'(gVec[gb]), 32'h1);
    checkOutput("erase_grant_busy", 32'(gBusy[gb]), 32'h1);
    checkOutput("erase_grant_to_start", 32'(sCyc[sb] - gCyc[gb]), 32'd1);
    checkOutput("erase_num_cmds", 32'(sCyc.size() - sb), 32'd6);
    for (int k = 0; k < 6; k++) checkOutput($sformatf("erase_code%0d", k), 32'(sCode[sb+k]), 32'(eraseCodes[k]));
    checkOutput("erase_wren_addr", 32'(sAddr[sb]), 32'h0);
    checkOutput("erase_se_addr", 32'(sAddr[sb+1]), 32'h010000);
    checkOutput("erase_se_len", 32'(sLen[sb+1]), 32'd0);
    checkOutput("erase_rdsr_len", 32'(sLen[sb+2]), 32'd1);
    checkOutput("erase_wren_to_op", 32'(sCyc[sb+1] - cdCyc[cb]), 32'd1);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("erase_gap%0d", k), 32'(sCyc[sb+2+k] - cdCyc[cb+1+k]), 32'(GAP + 2));
    checkOutput("erase_done_vec", 32'(dVec[db]), 32'h1);
    checkOutput("erase_done_err", 32'(dErr[db]), 32'h0);
    checkOutput("erase_done_busy", 32'(dBusy[db]), 32'h1);
    checkOutput("erase_done_latency", 32'(dCyc[db] - cdCyc[cb+5]), 32'd1);
    checkOutput("erase_done_once", 32'(dCyc.size() - db), 32'd1);
    checkOutput("erase_err_pulses", 32'(errPulses - ep), 32'd0);
    checkOutput("erase_idle_busy", 32'(busy), 32'd0);

    $display("[TB] read alone");
    sb = sCyc.size(); cb = cdCyc.size(); gb = gCyc.size(); db = dCyc.size();
    applyStimulus(2, 24'h000100, 16'd256);
    waitFor("read_done_seen", 3, db + 1, 200);
    repeat (3) stepCycle();
    checkOutput("read_grant", 32'(gVec[gb]), 32'h4);
    checkOutput("read_num_cmds", 32'(sCyc.size() - sb), 32'd1);
    checkOutput("read_code", 32'(sCode[sb]), 32'h03);
    checkOutput("read_addr", 32'(sAddr[sb]), 32'h000100);
    checkOutput("read_len", 32'(sLen[sb]), 32'd256);
    checkOutput("read_grant_to_start", 32'(sCyc[sb] - gCyc[gb]), 32'd1);
    checkOutput("read_done_vec", 32'(dVec[db]), 32'h4);
    checkOutput("read_done_latency", 32'(dCyc[db] - cdCyc[cb]), 32'd1);
    checkOutput("read_done_err", 32'(dErr[db]), 32'h0);

    $display("[TB] three simultaneous requests after reset");
    rst_n = 1'b0;
    repeat (2) stepCycle();
    rst_n = 1'b1;
    stepCycle();
    sb = sCyc.size(); cb = cdCyc.size(); gb = gCyc.size(); db = dCyc.size();
    wipPolls = 0;
    applyStimulus(0, 24'h020000, 16'h0000);
    applyStimulus(1, 24'h030000, 16'd64);
    applyStimulus(2, 24'h000200, 16'd16);
    waitFor("mix_three_grants", 2, gb + 3, 600);
    applyStimulus(0, 24'h040000, 16'h0000);
    waitFor("mix_four_dones", 3, db + 4, 600);
    repeat (4) stepCycle();
    checkOutput("mix_grant0", 32'(gVec[gb]), 32'h1);
    checkOutput("mix_grant1", 32'(gVec[gb+1]), 32'h2);
    checkOutput("mix_grant2", 32'(gVec[gb+2]), 32'h4);
    checkOutput("mix_grant3", 32'(gVec[gb+3]), 32'h1);
    checkOutput("mix_num_cmds", 32'(sCyc.size() - sb), 32'd10);
    for (int k = 0; k < 10; k++) checkOutput($sformatf("mix_code%0d", k), 32'(sCode[sb+k]), 32'(mixCodes[k]));
    checkOutput("mix_pp_addr", 32'(sAddr[sb+4]), 32'h030000);
    checkOutput("mix_pp_len", 32'(sLen[sb+4]), 32'd64);
    checkOutput("mix_rd_addr", 32'(sAddr[sb+6]), 32'h000200);
    checkOutput("mix_se2_addr", 32'(sAddr[sb+8]), 32'h040000);
    checkOutput("mix_done_to_grant", 32'(gCyc[gb+1] - dCyc[db]), 32'd2);
    checkOutput("mix_done_last", 32'(dVec[db+3]), 32'h1);

    $display("[TB] poll timeout with WIP stuck");
    sb = sCyc.size(); cb = cdCyc.size(); db = dCyc.size(); ep = errPulses;
    wipPolls = 1000;
    applyStimulus(0, 24'h050000, 16'h0000);
    waitFor("tout_done_seen", 3, db + 1, 600);
    repeat (4) stepCycle();
    n = 0;
    for (int k = sb; k < sCyc.size(); k++) if (sCode[k] == OP_RDSR) n++;
    checkOutput("tout_rdsr_count", 32'(n), 32'(PMAX));
    checkOutput("tout_done_vec", 32'(dVec[db]), 32'h1);
    checkOutput("tout_err_with_done", 32'(dErr[db]), 32'h1);
    checkOutput("tout_err_pulses", 32'(errPulses - ep), 32'd1);
    checkOutput("tout_done_latency", 32'(dCyc[db] - cdCyc[cdCyc.size()-1]), 32'd1);

    $display("[TB] reset during program GAP");
    cb = cdCyc.size();
    wipPolls = 0;
    applyStimulus(1, 24'h060000, 16'd32);
    waitFor("rst_prog_two_cmds", 1, cb + 2, 200);
    repeat (3) stepCycle();
    db = dCyc.size();
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    repeat (3) stepCycle();
    checkOutput("midrst_no_done", 32'(dCyc.size() - db), 32'd0);
    checkOutput("midrst_req_held", 32'(req), 32'h2);
    sb = sCyc.size(); gb = gCyc.size();
    rst_n = 1'b1;
    waitFor("restart_done_seen", 3, db + 1, 300);
    repeat (3) stepCycle();
    checkOutput("restart_grant", 32'(gVec[gb]), 32'h2);
    checkOutput("restart_wren", 32'(sCode[sb]), 32'h06);
    checkOutput("restart_pp", 32'(sCode[sb+1]), 32'h02);
    checkOutput("restart_pp_addr", 32'(sAddr[sb+1]), 32'h060000);
    checkOutput("restart_done_vec", 32'(dVec[db]), 32'h2);

    checkOutput("no_start_on_done", 32'(overlapCnt), 32'd0);
    checkOutput("cmd_fields_stable", 32'(unstableCnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
